// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver.
// The line is synchronized, a falling edge arms the frame, the start bit is
// confirmed at its middle, and every following bit is sampled one bit period
// later. A good stop bit loads rx_data and pulses rx_valid. A low stop bit
// pulses frame_err instead.
module uart_rx #(
  parameter int SAMPLING  = 16,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bclk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err
);

  localparam int CW = $clog2(SAMPLING);
  localparam logic [CW-1:0] HALF_LAST = CW'(SAMPLING / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(SAMPLING - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic                 sync1, rx_s, rx_p;
  logic [CW-1:0]        tick_cnt, tick_nxt;
  logic [2:0]           bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 load, ferr;

  // Two-flop synchronizer for the asynchronous line, preset to idle-high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx;
      rx_s  <= sync1;
    end
  end

  // Previous-tick line value used for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_p <= 1'b1;
    end else if (bclk) begin
      rx_p <= rx_s;
    end
  end

  // State, counters and shift register. They move only on bclk ticks.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      tick_cnt <= CNT_ZERO;
      bit_idx  <= 3'd0;
      shreg    <= '0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_idx  <= idx_nxt;
      shreg    <= shreg_nxt;
    end
  end

  // Next-state, counter and shift logic, plus the end-of-frame strobes.
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    load      = 1'b0;
    ferr      = 1'b0;
    if (bclk) begin
      case (state)
        IDLE: begin
          if (rx_p && !rx_s) begin
            state_nxt = START;
            tick_nxt  = CNT_ZERO;
          end else begin
            state_nxt = IDLE;
          end
        end
        START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_nxt = CNT_ZERO;
            idx_nxt  = 3'd0;
            if (!rx_s) begin
              state_nxt = DATA;
            end else begin
              state_nxt = IDLE;   // glitch, not a real start bit
            end
          end else begin
            tick_nxt = tick_cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (tick_cnt == FULL_LAST) begin
            tick_nxt  = CNT_ZERO;
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state_nxt = STOP;
              idx_nxt   = 3'd0;
            end else begin
              idx_nxt = bit_idx + 3'd1;
            end
          end else begin
            tick_nxt = tick_cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (tick_cnt == FULL_LAST) begin
            tick_nxt  = CNT_ZERO;
            state_nxt = IDLE;
            if (rx_s) begin
              load = 1'b1;
            end else begin
              ferr = 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + CNT_ONE;
          end
        end
        default: begin
          state_nxt = IDLE;
          tick_nxt  = CNT_ZERO;
          idx_nxt   = 3'd0;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  // Registered outputs. The strobes last one cycle. rx_data holds between frames.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= load;
      frame_err <= ferr;
      if (load) begin
        rx_data <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level bench for uart_rx (SAMPLING=16, 8 data bits,
// one bclk tick every 4 clk cycles). Expected results come from the
// serial framing rules, not from the receiver's internal structure.
module tb_uart_rx;
  localparam int SAMPLING  = 16;
  localparam int DATA_BITS = 8;
  localparam int TPB       = 4;                // clk cycles per bclk tick
  localparam int BIT_CLKS  = SAMPLING * TPB;   // clk cycles per bit

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       bclk = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;

  int         checks = 0;
  int         errors = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] exp_data = 8'h00;   // model: last well-framed character

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    int         exp_valid;
    int         exp_ferr;
    logic [7:0] exp_rxdata;
  } vec_t;

  vec_t vecs[7];

  uart_rx #(.SAMPLING(SAMPLING), .DATA_BITS(DATA_BITS)) dut (
    .clk(clk), .reset(reset), .bclk(bclk), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // One-cycle bclk tick every TPB clk cycles.
  initial begin
    forever begin
      repeat (TPB - 1) @(posedge clk);
      #1 bclk = 1'b1;
      @(posedge clk);
      #1 bclk = 1'b0;
    end
  end

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Pulse monitor sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid || frame_err) begin
        check("pulse_exclusive", int'(rx_valid & frame_err), 0);
        check("pulse_width", int'(prev_pulse), 0);
        if (rx_valid) valid_cnt++;
        if (frame_err) ferr_cnt++;
      end
      prev_pulse = rx_valid | frame_err;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  // Send a frame and check it against the model. The stop-bit sample falls
  // inside the stop bit, so the result must be visible when the stop bit ends.
  task automatic model_frame(input string tag, input logic [7:0] d, input logic stop, input int gap);
    int v0, f0;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_raw(d, stop);
    if (stop) exp_data = d;
    check({tag, "_valid"}, valid_cnt - v0, stop ? 1 : 0);
    check({tag, "_ferr"}, ferr_cnt - f0, stop ? 0 : 1);
    check({tag, "_data"}, int'(rx_data), int'(exp_data));
    idle_bits(gap);
  endtask

  initial begin
    int v0, f0;
    logic [7:0] d;
    logic st;
    vecs[0] = '{8'hA5, 1'b1, 1, 1, 0, 8'hA5};
    vecs[1] = '{8'h3C, 1'b0, 1, 0, 1, 8'hA5};
    vecs[2] = '{8'h00, 1'b1, 0, 1, 0, 8'h00};
    vecs[3] = '{8'hFF, 1'b1, 1, 1, 0, 8'hFF};
    vecs[4] = '{8'h5A, 1'b1, 0, 1, 0, 8'h5A};
    vecs[5] = '{8'h0F, 1'b0, 2, 0, 1, 8'h5A};
    vecs[6] = '{8'h81, 1'b1, 1, 1, 0, 8'h81};

    // Reset: line activity is ignored and the outputs read zero.
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1 rx = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    check("reset_rx_data", int'(rx_data), 0);
    check("reset_rx_valid", int'(rx_valid), 0);
    check("reset_frame_err", int'(frame_err), 0);
    @(posedge clk);
    #1 rx = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    v0 = valid_cnt;
    f0 = ferr_cnt;
    idle_bits(2);
    check("post_reset_quiet", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    exp_data = 8'h00;

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_raw(vecs[i].data, vecs[i].stop);
      check($sformatf("vec%0d_valid", i), valid_cnt - v0, vecs[i].exp_valid);
      check($sformatf("vec%0d_ferr", i), ferr_cnt - f0, vecs[i].exp_ferr);
      check($sformatf("vec%0d_data", i), int'(rx_data), int'(vecs[i].exp_rxdata));
      idle_bits(vecs[i].gap);
    end
    exp_data = 8'h81;

    // False start: the line is low for 4 ticks, then goes high.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (4 * TPB) @(posedge clk);
    #1 rx = 1'b1;
    idle_bits(2);
    check("false_start_valid", valid_cnt - v0, 0);
    check("false_start_ferr", ferr_cnt - f0, 0);
    model_frame("after_false_start", 8'h5A, 1'b1, 1);

    // Break: the line is held low for 40 bit times. Exactly one frame error.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    rx = 1'b0;
    repeat (40 * BIT_CLKS) @(posedge clk);
    #1 rx = 1'b1;
    idle_bits(2);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_valid", valid_cnt - v0, 0);
    model_frame("after_break", 8'h11, 1'b1, 1);

    // Reset in the middle of data bit 3 of 0x81. The frame is abandoned.
    v0 = valid_cnt;
    f0 = ferr_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    rx = 1'b0;
    repeat (BIT_CLKS / 2) @(posedge clk);
    #1 reset = 1'b0;
    rx = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("midreset_rx_data", int'(rx_data), 0);
    @(posedge clk);
    #1 reset = 1'b1;
    idle_bits(3);
    check("midreset_no_pulse", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    exp_data = 8'h00;
    check("midreset_data_cleared", int'(rx_data), int'(exp_data));
    model_frame("after_midreset", 8'h42, 1'b1, 1);

    // Randomized frames with occasional bad stop bits and glitches.
    for (int n = 0; n < 20; n++) begin
      d  = 8'($urandom);
      st = ($urandom_range(0, 4) != 0);
      model_frame($sformatf("rnd%0d", n), d, st, st ? $urandom_range(0, 2) : $urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) begin
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        repeat ($urandom_range(1, 5) * TPB) @(posedge clk);
        #1 rx = 1'b1;
        idle_bits(1);
        check($sformatf("rnd%0d_glitch", n), (valid_cnt - v0) + (ferr_cnt - f0), 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
